// File: rtl/map_request_server_pkg.sv
// Shared types and defaults for the map request server and its arbiter.
package map_request_server_pkg;

  // One map cell: 0 is open floor, anything else is some kind of wall.
  typedef logic [4:0] cell_t;

  localparam int    MAP_N    = 24;
  localparam cell_t OOR_CELL = 5'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  // Address bits needed to index every cell of an edgeLen x edgeLen map.
  function automatic int addrWidth(input int edgeLen);
    return $clog2(edgeLen * edgeLen);
  endfunction

endpackage

// File: rtl/map_request_server_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, the port after the
// last granted one has top priority on the next arbitration.
module rr_arbiter #(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_advance,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [IDX_W-1:0]     o_grantIdx
);

  logic [IDX_W-1:0]       r_ptr;
  logic [2*NUM_PORTS-1:0] w_reqDbl;
  int                     w_offset;
  int                     w_idxInt;

  // Rotate the requests so the priority port sits at bit 0, then take the lowest set bit.
  always_comb begin
    w_reqDbl = {i_req, i_req} >> r_ptr;
    w_offset = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_reqDbl[k]) begin
        w_offset = k;
      end
    end
    w_idxInt   = (w_offset + int'(r_ptr)) % NUM_PORTS;
    o_grantIdx = IDX_W'(w_idxInt);
    o_grant    = (|i_req) ? (NUM_PORTS'(1) << o_grantIdx) : '0;
  end

  // Move the priority pointer just past the port that was actually granted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_grantIdx == IDX_W'(NUM_PORTS - 1)) ? '0 : o_grantIdx + 1'b1;
    end
  end

endmodule

// File: rtl/map_request_server.sv
// Serves map-cell reads from several ray-stepping requesters out of one
// shared map BRAM, and lets the maze loader write cells when the port is idle.
module map_request_server
  import map_request_server_pkg::*;
#(
  parameter  int    N            = MAP_N,
  parameter  int    NUM_PORTS    = 2,
  parameter  int    BRAM_LATENCY = 2,
  parameter  cell_t OOR_VALUE    = OOR_CELL,
  localparam int    ADDR_W       = addrWidth(N)
) (
  input  logic                             pixel_clk_in,
  input  logic                             rst_n_in,
  input  logic [NUM_PORTS-1:0]             req_in,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_in,
  output cell_t                            data_out,
  output logic [NUM_PORTS-1:0]             valid_out,
  output logic [ADDR_W-1:0]                bram_addr_out,
  input  cell_t                            bram_dout_in,
  output logic                             bram_we_out,
  output cell_t                            bram_din_out,
  input  logic                             wr_en_in,
  input  logic [ADDR_W-1:0]                wr_addr_in,
  input  cell_t                            wr_data_in,
  output logic                             wr_ready_out,
  output logic                             busy_out
);

  localparam int                IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int                CNT_W     = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BRAM_LATENCY - 1);
  localparam logic [ADDR_W:0]   MAP_CELLS = (ADDR_W + 1)'(N * N);

  state_t                           r_state;
  logic [NUM_PORTS-1:0]             r_pending;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] r_addr;
  logic [IDX_W-1:0]                 r_grantIdx;
  logic [CNT_W-1:0]                 r_cnt;
  cell_t                            r_data;
  logic [NUM_PORTS-1:0]             r_valid;
  logic [ADDR_W-1:0]                r_bramAddr;
  logic                             r_we;
  cell_t                            r_din;

  logic [NUM_PORTS-1:0] w_grant;
  logic [IDX_W-1:0]     w_grantIdx;
  logic                 w_anyPending;
  logic                 w_advance;
  logic [NUM_PORTS-1:0] w_clearMask;
  logic [ADDR_W-1:0]    w_selAddr;
  logic                 w_selInRange;
  logic                 w_wrInRange;
  logic [NUM_PORTS-1:0] w_respOneHot;

  assign w_anyPending = |r_pending;
  // A loader write in IDLE always wins, so reads are only granted without one.
  assign w_advance    = (r_state == ST_IDLE) && !wr_en_in && w_anyPending;
  assign w_clearMask  = w_advance ? w_grant : '0;
  assign w_selAddr    = r_addr[w_grantIdx];
  assign w_selInRange = {1'b0, w_selAddr} < MAP_CELLS;
  assign w_wrInRange  = {1'b0, wr_addr_in} < MAP_CELLS;
  assign w_respOneHot = NUM_PORTS'(1) << r_grantIdx;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arbiter (
    .i_clk      (pixel_clk_in),
    .i_rst_n    (rst_n_in),
    .i_req      (r_pending),
    .i_advance  (w_advance),
    .o_grant    (w_grant),
    .o_grantIdx (w_grantIdx)
  );

  // Latch request addresses; a new request always sets pending, even on the grant edge, so none is lost.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      r_pending <= '0;
      r_addr    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clearMask) | req_in;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (req_in[p]) begin
          r_addr[p] <= addr_in[p];
        end
      end
    end
  end

  // Read/write sequencer: IDLE issues a write or a read, WAIT covers BRAM latency, RESPOND pulses valid.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      r_state    <= ST_IDLE;
      r_grantIdx <= '0;
      r_cnt      <= '0;
      r_data     <= '0;
      r_valid    <= '0;
      r_bramAddr <= '0;
      r_we       <= 1'b0;
      r_din      <= '0;
    end else begin
      r_we    <= 1'b0;
      r_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (wr_en_in) begin
            if (w_wrInRange) begin
              r_bramAddr <= wr_addr_in;
              r_din      <= wr_data_in;
              r_we       <= 1'b1;
            end
          end else if (w_anyPending) begin
            r_grantIdx <= w_grantIdx;
            r_cnt      <= '0;
            if (w_selInRange) begin
              r_bramAddr <= w_selAddr;
              r_state    <= ST_WAIT;
            end else begin
              r_data  <= OOR_VALUE;
              r_state <= ST_RESPOND;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == CNT_LAST) begin
            r_data  <= bram_dout_in;
            r_cnt   <= '0;
            r_state <= ST_RESPOND;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESPOND: begin
          r_valid <= w_respOneHot;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out      = r_data;
  assign valid_out     = r_valid;
  assign bram_addr_out = r_bramAddr;
  assign bram_we_out   = r_we;
  assign bram_din_out  = r_din;
  assign wr_ready_out  = (r_state == ST_IDLE);
  assign busy_out      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_map_request_server.sv
// Bench for map_request_server: directed scenarios plus randomized reads and
// writes, checked by a per-port scoreboard fed from a reference map model.
module tb_map_request_server;

  localparam int          CELLS  = 576;
  localparam int          ADDR_W = 10;
  localparam logic [4:0]  OOR    = 5'd1;

  typedef struct {
    logic [4:0] data;
    int         cycle;
  } exp_t;

  logic                   pixelClk = 1'b0;
  logic                   rstN;
  logic [1:0]             reqIn;
  logic [1:0][ADDR_W-1:0] addrIn;
  logic [4:0]             dataOut;
  logic [1:0]             validOut;
  logic [ADDR_W-1:0]      bramAddr;
  logic [4:0]             bramDout;
  logic                   bramWe;
  logic [4:0]             bramDin;
  logic                   wrEn;
  logic [ADDR_W-1:0]      wrAddr;
  logic [4:0]             wrData;
  logic                   wrReady;
  logic                   busy;

  logic [4:0] refMem [0:CELLS-1];
  logic [4:0] bramMem[0:CELLS-1];
  exp_t       expQ[2][$];
  int         cycle    = 0;
  int         checks   = 0;
  int         failures = 0;

  map_request_server #(
    .N            (24),
    .NUM_PORTS    (2),
    .BRAM_LATENCY (2),
    .OOR_VALUE    (5'd1)
  ) dut (
    .pixel_clk_in  (pixelClk),
    .rst_n_in      (rstN),
    .req_in        (reqIn),
    .addr_in       (addrIn),
    .data_out      (dataOut),
    .valid_out     (validOut),
    .bram_addr_out (bramAddr),
    .bram_dout_in  (bramDout),
    .bram_we_out   (bramWe),
    .bram_din_out  (bramDin),
    .wr_en_in      (wrEn),
    .wr_addr_in    (wrAddr),
    .wr_data_in    (wrData),
    .wr_ready_out  (wrReady),
    .busy_out      (busy)
  );

  always #5 pixelClk = ~pixelClk;

  always @(posedge pixelClk) cycle <= cycle + 1;

  // Map BRAM: the DUT's address register is the first latency stage, this read register the second.
  always @(posedge pixelClk) begin
    if (!rstN) begin
      for (int i = 0; i < CELLS; i++) bramMem[i] <= refMem[i];
    end else if (bramWe && bramAddr < ADDR_W'(CELLS)) begin
      bramMem[bramAddr] <= bramDin;
    end
    bramDout <= (bramAddr < ADDR_W'(CELLS)) ? bramMem[bramAddr] : 5'd0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Monitor: every valid pulse is matched against the oldest expectation for that port.
  always @(negedge pixelClk) begin
    if (validOut !== 2'b00) begin
      checkOutput("valid_onehot", 32'($onehot(validOut)), 1);
      for (int p = 0; p < 2; p++) begin
        if (validOut[p] === 1'b1) begin
          if (expQ[p].size() == 0) begin
            checkOutput($sformatf("unexpected_valid_p%0d", p), 1, 0);
          end else begin
            exp_t e;
            e = expQ[p].pop_front();
            checkOutput($sformatf("data_p%0d", p), dataOut, e.data);
            if (e.cycle >= 0) checkOutput($sformatf("latency_p%0d", p), cycle, e.cycle);
          end
        end
      end
    end
  end

  function automatic logic [4:0] refRead(input int a);
    return (a < CELLS) ? refMem[a] : OOR;
  endfunction

  task automatic tick();
    @(posedge pixelClk);
    #1;
  endtask

  // Pulse requests for one cycle; offsets (relative to now, <0 = untimed) give expected valid cycles.
  task automatic applyStimulus(input logic [1:0] mask, input int a0, input int a1,
                               input bit push, input int off0, input int off1);
    int   e;
    int   a[2];
    int   off[2];
    exp_t x;
    e = cycle;
    a[0] = a0; a[1] = a1; off[0] = off0; off[1] = off1;
    reqIn     = mask;
    addrIn[0] = ADDR_W'(a0);
    addrIn[1] = ADDR_W'(a1);
    if (push) begin
      for (int p = 0; p < 2; p++) begin
        if (mask[p]) begin
          x.data  = refRead(a[p]);
          x.cycle = (off[p] < 0) ? -1 : e + off[p];
          expQ[p].push_back(x);
        end
      end
    end
    tick();
    reqIn = 2'b00;
  endtask

  task automatic applyWrite(input int addr, input logic [4:0] data);
    checkOutput("wr_ready", wrReady, 1);
    wrEn   = 1'b1;
    wrAddr = ADDR_W'(addr);
    wrData = data;
    tick();
    wrEn = 1'b0;
    checkOutput("wr_we", bramWe, (addr < CELLS) ? 1 : 0);
    if (addr < CELLS) begin
      refMem[addr] = data;
      checkOutput("wr_addr", bramAddr, addr);
      checkOutput("wr_din", bramDin, data);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_data"}, dataOut, 0);
    checkOutput({tag, "_valid"}, validOut, 0);
    checkOutput({tag, "_bram_addr"}, bramAddr, 0);
    checkOutput({tag, "_we"}, bramWe, 0);
    checkOutput({tag, "_din"}, bramDin, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_wr_ready"}, wrReady, 1);
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    repeat (2) tick();
    rstN = 1'b1;
    tick();
  endtask

  task automatic waitDrain(input string tag);
    int guard;
    guard = 0;
    while ((expQ[0].size() != 0 || expQ[1].size() != 0) && guard < 100) begin
      tick();
      guard++;
    end
    checkOutput({tag, "_drain"}, expQ[0].size() + expQ[1].size(), 0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e;
    for (int i = 0; i < CELLS; i++) refMem[i] = 5'($urandom_range(0, 31));
    refMem[25] = 5'd3;
    refMem[5]  = 5'd11;
    refMem[6]  = 5'd22;
    refMem[30] = 5'd0;
    rstN   = 1'b0;
    reqIn  = 2'b00;
    addrIn = '0;
    wrEn   = 1'b0;
    wrAddr = '0;
    wrData = '0;
    repeat (3) tick();
    checkResetValues("reset");
    rstN = 1'b1;
    tick();

    $display("[TB] single read, port 0, cell 25");
    applyStimulus(2'b01, 25, 0, 1'b1, 5, -1);
    waitDrain("t1");

    $display("[TB] simultaneous requests from both ports after reset");
    applyReset();
    applyStimulus(2'b11, 1, 2, 1'b1, 5, 9);
    waitDrain("t2");

    $display("[TB] out-of-range read on port 1");
    applyStimulus(2'b10, 0, 600, 1'b1, -1, 3);
    waitDrain("t3");

    $display("[TB] write takes priority over pending read");
    refMem[30] = 5'd7;
    applyStimulus(2'b01, 30, 0, 1'b1, 6, -1);
    wrEn   = 1'b1;
    wrAddr = ADDR_W'(30);
    wrData = 5'd7;
    tick();
    wrEn = 1'b0;
    checkOutput("t4_we", bramWe, 1);
    checkOutput("t4_wr_addr", bramAddr, 30);
    checkOutput("t4_wr_din", bramDin, 7);
    checkOutput("t4_busy_during_write", busy, 0);
    tick();
    checkOutput("t4_we_pulse_end", bramWe, 0);
    checkOutput("t4_busy_after_grant", busy, 1);
    waitDrain("t4");
    applyWrite(700, 5'd9);

    $display("[TB] reset during WAIT discards the read");
    applyStimulus(2'b01, 25, 0, 1'b0, -1, -1);
    tick();
    checkOutput("t5_busy_wait", busy, 1);
    rstN = 1'b0;
    repeat (2) tick();
    checkResetValues("t5_reset");
    rstN = 1'b1;
    repeat (12) tick();
    checkOutput("t5_idle_after", busy, 0);

    $display("[TB] repeated request before grant overwrites address");
    applyStimulus(2'b10, 0, 40, 1'b1, -1, 5);
    applyStimulus(2'b01, 5, 0, 1'b0, -1, -1);
    applyStimulus(2'b01, 6, 0, 1'b1, 7, -1);
    repeat (3) tick();
    checkOutput("t6_bram_addr", bramAddr, 6);
    waitDrain("t6");

    $display("[TB] randomized reads and loader writes");
    for (int it = 0; it < 400; it++) begin
      logic [1:0] m;
      int         a0;
      int         a1;
      m  = 2'b00;
      a0 = int'($urandom_range(0, 639));
      a1 = int'($urandom_range(0, 639));
      if (expQ[0].size() == 0 && expQ[1].size() == 0 && $urandom_range(0, 3) == 0) begin
        applyWrite(int'($urandom_range(0, 700)), 5'($urandom_range(0, 31)));
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (expQ[p].size() == 0 && $urandom_range(0, 2) == 0) m[p] = 1'b1;
        end
        if (m != 2'b00) applyStimulus(m, a0, a1, 1'b1, -1, -1);
        else tick();
      end
    end
    waitDrain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
